mem_port_arbiter: RTL and testbench

- Arbitrates one single-port data/instruction SRAM between two requesters: instruction fetch (IF) and load/store unit (LS).
- Sits between the processor datapath and the shared memory macro.
- Issues at most one memory access per cycle, tags in-flight reads, and returns read data to the correct requester after a fixed memory latency.
- Has an LS-priority policy with a starvation bound for IF, and supports an LS lock for read-modify-write sequences.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LS) arbiter for a shared single-port SRAM with read tagging,
// LS priority with IF starvation bound, and LS lock. Optional macro: ARB_PERF_CNT_EN.

package mem_port_arbiter_pkg;
   typedef struct packed {
      logic valid;
      logic owner_ls;
   } tag_t;
endpackage

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_ls_req,
   input  logic                i_ls_we,
   input  logic                i_ls_lock,
   input  logic [ADDR_W-1:0]   i_ls_addr,
   input  logic [DATA_W-1:0]   i_ls_wdata,
   input  logic [DATA_W/8-1:0] i_ls_bmask,
   output logic                o_ls_gnt,
   output logic                o_ls_rvalid,
   output logic [DATA_W-1:0]   o_ls_rdata,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_bmask,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_busy,
   output logic [31:0]         o_if_wait_cnt,
   output logic [31:0]         o_ls_wait_cnt
);

   localparam int unsigned BMASK_W  = DATA_W / 8;
   localparam int unsigned STARVE_W = 4;
   localparam int unsigned LAST     = RD_LAT - 1;

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } lock_state_e;

   lock_state_e         state_q;
   logic [STARVE_W-1:0] starve_q, starve_d;
   tag_t                tag_q [RD_LAT];
   tag_t                tag_d;
   tag_t                tag_out;

   logic starved;
   logic if_win;
   logic any_valid;

   // Arbitration: LS first, IF forced once starved, IF excluded while locked.
   always_comb begin
      starved  = (starve_q == STARVE_W'(STARVE_MAX));
      if_win   = i_if_req && (state_q == ST_OPEN) && (!i_ls_req || starved);
      o_if_gnt = !i_reset && if_win;
      o_ls_gnt = !i_reset && i_ls_req && !if_win;
   end

   always_comb begin
      o_mem_en    = o_if_gnt | o_ls_gnt;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (o_if_gnt) begin
         o_mem_addr  = i_if_addr;
         o_mem_bmask = {BMASK_W{1'b1}};
      end else if (o_ls_gnt) begin
         o_mem_we    = i_ls_we;
         o_mem_addr  = i_ls_addr;
         o_mem_wdata = i_ls_wdata;
         o_mem_bmask = i_ls_bmask;
      end
   end

   // Starvation count only grows while IF waits behind LS grants.
   always_comb begin
      starve_d = starve_q;
      if (o_if_gnt || !i_if_req) begin
         starve_d = '0;
      end else if (o_ls_gnt && !starved) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_comb begin
      tag_d.valid    = o_mem_en && !o_mem_we;
      tag_d.owner_ls = o_ls_gnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_OPEN;
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
         case (state_q)
            ST_OPEN:   if (o_ls_gnt && i_ls_lock)  state_q <= ST_LOCKED;
            ST_LOCKED: if (o_ls_gnt && !i_ls_lock) state_q <= ST_OPEN;
            default:   state_q <= ST_OPEN;
         endcase
      end
   end

   // Tag pipe: stage LAST lines up with the memory's read data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_d;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      tag_out   = tag_q[LAST];
      any_valid = 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         any_valid = any_valid | tag_q[i].valid;
      end
      o_if_rvalid = !i_reset && tag_out.valid && !tag_out.owner_ls;
      o_ls_rvalid = !i_reset && tag_out.valid && tag_out.owner_ls;
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
      o_busy      = !i_reset && ((state_q == ST_LOCKED) || any_valid);
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] if_wait_q, if_wait_d;
   logic [31:0] ls_wait_q, ls_wait_d;

   // Saturating stall counters.
   always_comb begin
      if_wait_d = if_wait_q;
      ls_wait_d = ls_wait_q;
      if (i_if_req && !o_if_gnt && (if_wait_q != 32'hFFFF_FFFF)) begin
         if_wait_d = if_wait_q + 32'd1;
      end
      if (i_ls_req && !o_ls_gnt && (ls_wait_q != 32'hFFFF_FFFF)) begin
         ls_wait_d = ls_wait_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         if_wait_q <= '0;
         ls_wait_q <= '0;
      end else begin
         if_wait_q <= if_wait_d;
         ls_wait_q <= ls_wait_d;
      end
   end

   assign o_if_wait_cnt = if_wait_q;
   assign o_ls_wait_cnt = ls_wait_q;
`else
   assign o_if_wait_cnt = '0;
   assign o_ls_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level model
// (grant policy, lock, read-return queue, byte-masked reference memory).

module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int RD_LAT     = 3;
   localparam int STARVE_MAX = 4;

   logic        clk, rst;
   logic        if_req, ls_req, ls_we, ls_lock;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_bmask;
   logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid;
   logic [31:0] o_if_rdata, o_ls_rdata;
   logic        o_mem_en, o_mem_we, o_busy;
   logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
   logic [3:0]  o_mem_bmask;
   logic [31:0] o_if_wait_cnt, o_ls_wait_cnt;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_lock(ls_lock), .i_ls_addr(ls_addr),
      .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
      .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_if_wait_cnt(o_if_wait_cnt), .o_ls_wait_cnt(o_ls_wait_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      return w;
   endfunction

   // SRAM environment: responds to the DUT's memory port with RD_LAT read latency.
   logic [31:0] sram [logic [31:0]];
   logic [31:0] rd_pipe [RD_LAT];
   assign i_mem_rdata = rd_pipe[RD_LAT-1];

   always @(posedge clk) begin
      logic [31:0] cur;
      cur = sram.exists(o_mem_addr) ? sram[o_mem_addr] : init_word(o_mem_addr);
      for (int i = RD_LAT-1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (o_mem_en && !o_mem_we) ? cur : $urandom;
      if (o_mem_en && o_mem_we) sram[o_mem_addr] = merge(cur, o_mem_wdata, o_mem_bmask);
   end

   // Reference model state
   typedef struct {
      int          due;
      bit          ls;
      logic [31:0] data;
   } ret_t;
   ret_t        rq[$];
   logic [31:0] ref_mem [logic [31:0]];
   bit          m_locked;
   int          m_starve;
   logic [31:0] m_if_wait, m_ls_wait;
   bit          g_if, g_ls;
   logic        s_if_gnt, s_ls_gnt, s_busy, s_ls_rvalid;
   logic [31:0] s_if_wait, last_ls_rdata;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic step();
      bit          e_if, e_ls, ret_now;
      logic [31:0] e_ifd, e_lsd;
      ret_t        r;
      @(negedge clk);
      e_if = 1'b0;
      e_ls = 1'b0;
      if (!rst) begin
         if (m_locked) e_ls = ls_req;
         else if (if_req && ls_req) begin
            if (m_starve >= STARVE_MAX) e_if = 1'b1; else e_ls = 1'b1;
         end else begin
            e_if = if_req;
            e_ls = ls_req;
         end
      end
      ret_now = !rst && rq.size() > 0 && rq[0].due == cyc;
      e_ifd = 32'd0;
      e_lsd = 32'd0;
      if (ret_now) begin
         if (rq[0].ls) e_lsd = rq[0].data; else e_ifd = rq[0].data;
      end

      check("if_gnt", 32'(o_if_gnt), 32'(e_if));
      check("ls_gnt", 32'(o_ls_gnt), 32'(e_ls));
      check("mem_en", 32'(o_mem_en), 32'(e_if | e_ls));
      check("mem_we", 32'(o_mem_we), 32'(e_ls && ls_we));
      if (e_if) begin
         check("mem_addr_if", o_mem_addr, if_addr);
         check("mem_bmask_if", 32'(o_mem_bmask), 32'hF);
      end
      if (e_ls) check("mem_addr_ls", o_mem_addr, ls_addr);
      if (e_ls && ls_we) begin
         check("mem_wdata", o_mem_wdata, ls_wdata);
         check("mem_bmask_ls", 32'(o_mem_bmask), 32'(ls_bmask));
      end
      check("if_rvalid", 32'(o_if_rvalid), 32'(ret_now && !rq[0].ls));
      check("ls_rvalid", 32'(o_ls_rvalid), 32'(ret_now && rq[0].ls));
      check("if_rdata", o_if_rdata, e_ifd);
      check("ls_rdata", o_ls_rdata, e_lsd);
      check("busy", 32'(o_busy), 32'(!rst && (m_locked || rq.size() > 0)));
`ifdef ARB_PERF_CNT_EN
      if (!rst) begin
         check("if_wait", o_if_wait_cnt, m_if_wait);
         check("ls_wait", o_ls_wait_cnt, m_ls_wait);
      end
`else
      check("if_wait0", o_if_wait_cnt, 32'd0);
      check("ls_wait0", o_ls_wait_cnt, 32'd0);
`endif
      s_if_gnt    = o_if_gnt;
      s_ls_gnt    = o_ls_gnt;
      s_busy      = o_busy;
      s_ls_rvalid = o_ls_rvalid;
      s_if_wait   = o_if_wait_cnt;
      if (o_ls_rvalid) last_ls_rdata = o_ls_rdata;

      // Advance model to the next edge
      if (rst) begin
         rq.delete();
         m_locked  = 1'b0;
         m_starve  = 0;
         m_if_wait = 32'd0;
         m_ls_wait = 32'd0;
      end else begin
         if (ret_now) void'(rq.pop_front());
         if (e_if) begin
            r.due = cyc + RD_LAT; r.ls = 1'b0; r.data = ref_rd(if_addr);
            rq.push_back(r);
         end
         if (e_ls) begin
            if (ls_we) ref_mem[ls_addr] = merge(ref_rd(ls_addr), ls_wdata, ls_bmask);
            else begin
               r.due = cyc + RD_LAT; r.ls = 1'b1; r.data = ref_rd(ls_addr);
               rq.push_back(r);
            end
            m_locked = ls_lock;
         end
         if (e_if || !if_req) m_starve = 0;
         else if (e_ls && m_starve < STARVE_MAX) m_starve++;
         if (if_req && !e_if && m_if_wait != 32'hFFFF_FFFF) m_if_wait++;
         if (ls_req && !e_ls && m_ls_wait != 32'hFFFF_FFFF) m_ls_wait++;
      end
      g_if = e_if;
      g_ls = e_ls;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic new_if();
      if_req  = ($urandom % 4) != 0;
      if_addr = 32'($urandom_range(0, 15)) << 2;
   endtask

   task automatic new_ls();
      ls_req   = ($urandom % 3) != 0;
      ls_we    = 1'($urandom % 2);
      ls_lock  = ($urandom % 5) == 0;
      ls_addr  = 32'($urandom_range(0, 15)) << 2;
      ls_wdata = $urandom;
      ls_bmask = 4'($urandom);
   endtask

   task automatic drain();
      if_req = 1'b0;
      ls_req = 1'b0;
      for (int i = 0; i <= RD_LAT; i++) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_lock = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
      m_locked = 1'b0; m_starve = 0; m_if_wait = '0; m_ls_wait = '0;
      last_ls_rdata = '0;
      step();
      step();
      rst = 1'b0;
      step();

      // IF-only back-to-back reads
      for (int i = 0; i < 3; i++) begin
         if_req  = 1'b1;
         if_addr = 32'(i * 4);
         step();
         check("t1_if_gnt", 32'(s_if_gnt), 32'd1);
      end
      drain();

      // Continuous contention: LS x4 then IF
      if_req = 1'b1; if_addr = 32'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = 32'h20;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t2_pattern", 32'({s_if_gnt, s_ls_gnt}), (i % 5 == 4) ? 32'd2 : 32'd1);
      end
      drain();

      // Byte-masked write then read
      ls_req = 1'b1; ls_lock = 1'b0; ls_addr = 32'h100;
      ls_we = 1'b1; ls_wdata = 32'h0; ls_bmask = 4'hF; step();
      ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b0011; step();
      ls_we = 1'b0; step();
      drain();
      check("t3_rdata", last_ls_rdata, 32'h0000_BEEF);

      // Locked RMW with IF pending throughout
      if_req = 1'b1; if_addr = 32'h24;
      ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b1; ls_addr = 32'h40;
      step();
      check("t4_if_blk0", 32'(s_if_gnt), 32'd0);
      ls_req = 1'b0;
      step();
      check("t4_if_gap", 32'(s_if_gnt), 32'd0);
      check("t4_busy_gap", 32'(s_busy), 32'd1);
      ls_req = 1'b1; ls_we = 1'b1; ls_lock = 1'b0; ls_wdata = 32'h1234_5678; ls_bmask = 4'hF;
      step();
      check("t4_if_blk1", 32'(s_if_gnt), 32'd0);
      check("t4_busy_lock", 32'(s_busy), 32'd1);
      ls_req = 1'b0;
      step();
      check("t4_if_after", 32'(s_if_gnt), 32'd1);
      drain();

      // Reset with reads in flight
      ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = 32'h8;
      step();
      ls_addr = 32'hC;
      step();
      ls_req = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i <= RD_LAT; i++) begin
         step();
         check("t5_no_rvalid", 32'(s_ls_rvalid), 32'd0);
         check("t5_busy", 32'(s_busy), 32'd0);
      end

      // IF blocked five cycles by a locked LS sequence
      if_req = 1'b1; if_addr = 32'h30;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h34;
      for (int i = 0; i < 5; i++) begin
         ls_lock = (i < 4);
         step();
      end
      ls_req = 1'b0;
      step();
      check("t6_if_gnt", 32'(s_if_gnt), 32'd1);
`ifdef ARB_PERF_CNT_EN
      check("t6_if_wait", s_if_wait, 32'd5);
`else
      check("t6_if_wait", s_if_wait, 32'd0);
`endif
      drain();

      // Randomized traffic with occasional mid-stream resets
      new_if();
      new_ls();
      for (int i = 0; i < 3000; i++) begin
         step();
         if (rst) rst = 1'b0;
         else begin
            if (!if_req || g_if) new_if();
            if (!ls_req || g_ls) new_ls();
            rst = ($urandom_range(0, 199) == 0);
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
